set_assoc_cache_ctrl: RTL
=========================

Name: set_assoc_cache_ctrl

Overview:
- Parametrised set-associative, write-back, write-allocate cache controller. Generalises the direct-mapped byte cache to configurable ways, true-LRU replacement and valid/ready handshakes on both sides.
- Sits between a CPU load/store port and a byte-wide backing-memory port.
- Exposes saturating hit, miss and write-back counters for performance monitoring.

Parameters:
- ADDR_W, 32: CPU/memory byte-address width.
- DATA_W, 8: width of the CPU word and of a memory beat; one byte per beat.
- BLOCK_BYTES, 16: line size in beats; power of 2, at least 2.
- NUM_SETS, 256: number of sets; power of 2.
- WAYS, 2: associativity; one of 1, 2 or 4.
- Derived: OFF_W=log2(BLOCK_BYTES), IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse; cpu_rdata is valid on reads.
- cpu_rdata  out  DATA_W  read data.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request or write beat.
- mem_we  out  1  1=write beat, 0=line-read request.
- mem_addr  out  ADDR_W  beat address for writes; block-aligned address for reads.
- mem_wdata  out  DATA_W  write-beat data.
- mem_rvalid  in  1  read-beat valid; beats arrive in offset order.
- mem_rdata  in  DATA_W  read-beat data.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.
- wb_count  out  32  saturating count of dirty lines written back.

Behaviour:

Reset (reset low, asynchronous):
- State goes to IDLE; all valid and dirty bits clear.
- LRU ages reset to way index.
- Counters, cpu_resp_valid, cpu_rdata, mem_req_valid, mem_we, mem_addr and mem_wdata all go to 0.
- Data and tag arrays are not reset.
- A reset during WRITEBACK or ALLOCATE abandons the transfer; the line stays invalid.

Address split:
- Tag = addr[ADDR_W-1 : IDX_W+OFF_W]; index = addr[IDX_W+OFF_W-1 : OFF_W]; offset = addr[OFF_W-1 : 0].

FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: cpu_req_ready=1. A request is accepted on a clock edge when valid and ready are both high; addr, we and wdata are captured and the state goes to COMPARE. cpu_req_ready is 0 in every other state.
- COMPARE, hit (valid and tag match in any way):
  - Read: cpu_rdata is registered.
  - Write: the byte is written and the dirty bit set.
  - cpu_resp_valid is high for exactly the next cycle; the LRU is updated; hit_count increments unless this is a post-refill compare; the state returns to IDLE.
  - Hit latency: the response appears in the 2nd cycle after the acceptance edge.
- COMPARE, miss:
  - miss_count increments.
  - Victim = lowest-indexed invalid way; otherwise the way with the maximum LRU age.
  - Victim dirty: go to WRITEBACK. Otherwise: go to ALLOCATE.
- WRITEBACK:
  - Issues BLOCK_BYTES write beats: mem_we=1, mem_addr={victim_tag, index, beat}, mem_wdata = the line byte.
  - The beat counter advances only on mem_req_valid && mem_req_ready; mem_req_valid stays high between beats.
  - After the last beat: wb_count increments, the dirty bit clears, and the state goes to ALLOCATE.
- ALLOCATE:
  - Issues one read request: mem_req_valid=1, mem_we=0, mem_addr={tag, index, 0}.
  - It is held until mem_req_ready; then mem_req_valid drops.
  - Each mem_rvalid beat writes victim byte[beat]; the beat counter wraps at BLOCK_BYTES.
  - After the last beat: valid=1, dirty=0, tag written, and the state returns to COMPARE. That compare hits, performs the read/write, and does not increment hit_count.
- LRU (WAYS>1): each way has a log2(WAYS)-bit age per set. On any hit the accessed way's age becomes 0, and ways whose age was below its old age increment by 1. With WAYS=1, the victim is always way 0.
- Counters stick at 0xFFFFFFFF.
- mem_rvalid outside ALLOCATE is ignored. cpu_req_valid outside IDLE is ignored.

Test Plan:
Default parameters; 0x111AA0AB gives tag 0x111AA, index 0x0A, offset 0xB.
1. Read 0x111AA0AB on a cold cache -> mem read request at 0x111AA0A0; feed beats k=0..15 with data k -> cpu_rdata=0x0B, miss_count=1, hit_count=0, no mem write beats.
2. Read 0x111AA0AB again -> cpu_resp_valid 2 cycles after acceptance, rdata=0x0B, hit_count=1, no memory activity.
3. Write 0xAA to 0x111AA0AB, then read it -> hit_count=3, rdata=0xAA.
4. Read 0x222AA0AB with data 100+k -> fills way 1, no write-back, rdata=0x6F, miss_count=2, wb_count=0.
5. Read 0x111AA0A0 (hit), then read 0x333AA0A3 -> victim is the way holding 0x222AA (LRU, clean), so no write-back. Then write 0x555AA0A0 -> evicts the dirty 0x111AA line: 16 write beats at 0x111AA0A0..0x111AA0AF, beat 11 = 0xAA, wb_count=1. Toggle mem_req_ready every other cycle and confirm mem_addr and mem_wdata hold while stalled.
6. Assert reset at the 5th refill beat -> all outputs 0 immediately, FSM in IDLE. A later read of 0x111AA0AB misses (miss_count=1 after reset).

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// set_assoc_cache_ctrl
// Set-associative, write-back, write-allocate byte cache controller with
// true-LRU replacement. It sits between a CPU load/store port and a byte-wide
// backing memory, and keeps saturating hit/miss/write-back counters.
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   cpu_req_valid/ready           CPU request handshake (ready only in IDLE)
//   cpu_we, cpu_addr, cpu_wdata   request fields, captured on acceptance
//   cpu_resp_valid, cpu_rdata     one-cycle completion pulse and read data
//   mem_req_valid/ready           memory request / write-beat handshake
//   mem_we, mem_addr, mem_wdata   1 = write beat, 0 = block-aligned line read
//   mem_rvalid, mem_rdata         refill beats, in offset order
//   hit_count, miss_count, wb_count  saturating performance counters
module set_assoc_cache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int NUM_SETS    = 256,
    parameter int WAYS        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
);
    localparam int OFF_W   = $clog2(BLOCK_BYTES);
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_BYTES - 1);
    localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t            state_reg;
    logic [TAG_W-1:0]  req_tag_reg;
    logic [IDX_W-1:0]  req_idx_reg;
    logic [OFF_W-1:0]  req_off_reg;
    logic              req_we_reg;
    logic [DATA_W-1:0] req_wdata_reg;
    logic              post_refill_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [OFF_W-1:0]  beat_reg;          // shared by write-back and refill
    logic [DATA_W-1:0] refill_byte_reg;   // requested byte, caught during refill

    logic [NUM_SETS-1:0]            valid_reg [WAYS];
    logic [NUM_SETS-1:0]            dirty_reg [WAYS];
    logic [NUM_SETS-1:0][WAY_W-1:0] age_reg   [WAYS];

    logic [TAG_W-1:0]   tag_rd  [WAYS];
    logic [DATA_W-1:0]  rd_data [WAYS];
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_way;
    logic               victim_found;
    logic [WAY_W-1:0]   victim_age;
    logic [LINE_AW-1:0] rd_addr;
    logic [LINE_AW-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [WAYS-1:0]    wr_en;
    logic               tag_we;
    logic               wb_load;
    logic [OFF_W-1:0]   beat_inc;

    assign cpu_req_ready = (state_reg == IDLE);
    assign beat_inc      = beat_reg + OFF_W'(1);

    // Per-way storage: byte array with a registered read port, and a tag array.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [DATA_W-1:0] data_mem [NUM_SETS*BLOCK_BYTES];
        logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                data_mem[wr_addr] <= wr_data;
            end
            rd_q <= data_mem[rd_addr];
            if (tag_we && (victim_reg == WAY_W'(gi))) begin
                tag_mem[req_idx_reg] <= req_tag_reg;
            end
        end

        assign rd_data[gi] = rd_q;
        assign tag_rd[gi]  = tag_mem[req_idx_reg];
        assign hit_vec[gi] = valid_reg[gi][req_idx_reg] && (tag_rd[gi] == req_tag_reg);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    // Victim: lowest invalid way, else the oldest way of the set.
    always_comb begin
        victim_way   = '0;
        victim_found = 1'b0;
        victim_age   = age_reg[0][req_idx_reg];
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_reg[w][req_idx_reg]) begin
                victim_way   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_reg[w][req_idx_reg] > victim_age) begin
                    victim_age = age_reg[w][req_idx_reg];
                    victim_way = WAY_W'(w);
                end
            end
        end
    end

    // Read-port address. The data read is registered, so each state presents
    // the address whose byte it needs one cycle later. During write-back the
    // port runs one beat ahead of the outgoing beat and stays put on a stall.
    always_comb begin
        wb_load = (state_reg == WRITEBACK) && (!mem_req_valid || mem_req_ready);
        rd_addr = {req_idx_reg, req_off_reg};
        case (state_reg)
            IDLE:      rd_addr = cpu_addr[LINE_AW-1:0];
            COMPARE:   if (!hit) rd_addr = {req_idx_reg, {OFF_W{1'b0}}};
            WRITEBACK: rd_addr = {req_idx_reg, (wb_load ? beat_inc : beat_reg)};
            default:   rd_addr = {req_idx_reg, req_off_reg};
        endcase
    end

    // Single write port per way: CPU write hits and refill beats never overlap.
    always_comb begin
        wr_en   = '0;
        wr_addr = {req_idx_reg, req_off_reg};
        wr_data = req_wdata_reg;
        tag_we  = 1'b0;
        if (state_reg == COMPARE && hit && req_we_reg) begin
            wr_en[hit_way] = 1'b1;
        end
        if (state_reg == ALLOCATE && mem_rvalid) begin
            wr_en[victim_reg] = 1'b1;
            wr_addr           = {req_idx_reg, beat_reg};
            wr_data           = mem_rdata;
            tag_we            = (beat_reg == LAST_BEAT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            req_tag_reg     <= '0;
            req_idx_reg     <= '0;
            req_off_reg     <= '0;
            req_we_reg      <= 1'b0;
            req_wdata_reg   <= '0;
            post_refill_reg <= 1'b0;
            victim_reg      <= '0;
            beat_reg        <= '0;
            refill_byte_reg <= '0;
            cpu_resp_valid  <= 1'b0;
            cpu_rdata       <= '0;
            mem_req_valid   <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
            wb_count        <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
                age_reg[w]   <= {NUM_SETS{WAY_W'(w)}};
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_tag_reg   <= cpu_addr[ADDR_W-1:LINE_AW];
                        req_idx_reg   <= cpu_addr[LINE_AW-1:OFF_W];
                        req_off_reg   <= cpu_addr[OFF_W-1:0];
                        req_we_reg    <= cpu_we;
                        req_wdata_reg <= cpu_wdata;
                        state_reg     <= COMPARE;
                    end
                end

                COMPARE: begin
                    if (hit) begin
                        if (req_we_reg) begin
                            dirty_reg[hit_way][req_idx_reg] <= 1'b1;
                        end else begin
                            // The registered read predates the refill, so the
                            // byte captured on the fly is used after a refill.
                            cpu_rdata <= post_refill_reg ? refill_byte_reg : rd_data[hit_way];
                        end
                        cpu_resp_valid <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                age_reg[w][req_idx_reg] <= '0;
                            end else if (age_reg[w][req_idx_reg] < age_reg[hit_way][req_idx_reg]) begin
                                age_reg[w][req_idx_reg] <= age_reg[w][req_idx_reg] + WAY_W'(1);
                            end
                        end
                        if (!post_refill_reg && hit_count != CNT_MAX) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        post_refill_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        if (miss_count != CNT_MAX) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        victim_reg <= victim_way;
                        beat_reg   <= '0;
                        // The victim is invalid from now on, so an abandoned
                        // transfer never leaves a half-filled line visible.
                        valid_reg[victim_way][req_idx_reg] <= 1'b0;
                        if (valid_reg[victim_way][req_idx_reg] && dirty_reg[victim_way][req_idx_reg]) begin
                            state_reg <= WRITEBACK;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_we        <= 1'b0;
                            mem_addr      <= {req_tag_reg, req_idx_reg, {OFF_W{1'b0}}};
                            state_reg     <= ALLOCATE;
                        end
                    end
                end

                WRITEBACK: begin
                    if (!mem_req_valid) begin
                        // First cycle: the read port now holds beat 0.
                        mem_req_valid <= 1'b1;
                        mem_we        <= 1'b1;
                        mem_addr      <= {tag_rd[victim_reg], req_idx_reg, beat_reg};
                        mem_wdata     <= rd_data[victim_reg];
                        beat_reg      <= beat_inc;
                    end else if (mem_req_ready) begin
                        if (mem_addr[OFF_W-1:0] == LAST_BEAT) begin
                            if (wb_count != CNT_MAX) begin
                                wb_count <= wb_count + 32'd1;
                            end
                            dirty_reg[victim_reg][req_idx_reg] <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= {req_tag_reg, req_idx_reg, {OFF_W{1'b0}}};
                            beat_reg  <= '0;
                            state_reg <= ALLOCATE;
                        end else begin
                            mem_addr  <= {tag_rd[victim_reg], req_idx_reg, beat_reg};
                            mem_wdata <= rd_data[victim_reg];
                            beat_reg  <= beat_inc;
                        end
                    end
                end

                ALLOCATE: begin
                    if (mem_req_valid && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                    if (mem_rvalid) begin
                        if (beat_reg == req_off_reg) begin
                            refill_byte_reg <= mem_rdata;
                        end
                        beat_reg <= beat_inc;
                        if (beat_reg == LAST_BEAT) begin
                            valid_reg[victim_reg][req_idx_reg] <= 1'b1;
                            dirty_reg[victim_reg][req_idx_reg] <= 1'b0;
                            mem_req_valid   <= 1'b0;
                            post_refill_reg <= 1'b1;
                            state_reg       <= COMPARE;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
